memory_stage: RTL and testbench

//  M stage of the 5-stage core: consumes the X-stage result bundle and performs lw/sw against a

---
 rtl/memory_stage_pkg.sv | 58 +++++
 rtl/memory_stage_if.sv | 24 ++
 rtl/memory_stage_dmem_handshake.sv | 103 ++++++++++
 rtl/memory_stage.sv | 143 ++++++++++++++
 tb/tb_memory_stage.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the M stage: FSM encoding, exception codes,
// fixed register indices and the writeback bundle helper.
package memory_stage_pkg;

  // Default geometry / watchdog limit
  localparam int ADDR_W_DEF      = 12;
  localparam int TIMEOUT_CYC_DEF = 15;

  // Fixed destination registers
  localparam logic [4:0] REG_RSTATUS = 5'd30;
  localparam logic [4:0] REG_RA      = 5'd31;

  // Exception codes written to $rstatus
  localparam logic [31:0] EXC_ADD      = 32'd1;
  localparam logic [31:0] EXC_ADDI     = 32'd2;
  localparam logic [31:0] EXC_SUB      = 32'd3;
  localparam logic [31:0] EXC_MUL      = 32'd4;
  localparam logic [31:0] EXC_DIV      = 32'd5;
  localparam logic [31:0] EXC_MEMRANGE = 32'd6;
  localparam logic [31:0] EXC_MEMTO    = 32'd7;

  // Memory handshake FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Writeback bundle handed to the W stage
  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  // The part of a captured bundle needed once its memory access completes
  typedef struct packed {
    logic       is_lw;
    logic [4:0] rd;
  } cap_t;

  localparam wb_t WB_NONE = '0;

  // Builds a writeback; writes to $r0 collapse to "no writeback" so the
  // W stage never sees we=1 with rd=0.
  function automatic wb_t make_wb(input logic we, input logic [4:0] rd,
                                  input logic [31:0] data);
    wb_t w;
    w = WB_NONE;
    if (we && (rd != 5'd0)) begin
      w.we   = 1'b1;
      w.rd   = rd;
      w.data = data;
    end
    return w;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the M stage (master) and the
// variable-latency data memory (slave).
interface memory_stage_if #(
  parameter int ADDR_W = 12
) ();

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/memory_stage_dmem_handshake.sv
// Data-memory handshake engine: IDLE/ACCESS/DONE FSM plus the request
// holding registers. Optional ack watchdog built when MEM_TIMEOUT_EN is
// defined; without it ACCESS waits for dmem_ack indefinitely.
module memory_stage_dmem_handshake
  import memory_stage_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              start_we,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [31:0]       start_wdata,
  input  logic              ack,
  output logic              req,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  output state_e            state,
  output logic              complete,
  output logic              timeout_hit
);

  state_e            state_reg;
  logic              req_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;

  assign req   = req_reg;
  assign we    = we_reg;
  assign addr  = addr_reg;
  assign wdata = wdata_reg;
  assign state = state_reg;

  // An ack only counts while an access is outstanding
  assign complete = (state_reg == ST_ACCESS) && ack;

`ifdef MEM_TIMEOUT_EN
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT_CYC - 1);

  logic [3:0] to_cnt_reg;

  // Abort on the last allowed ACCESS cycle; an ack in that same cycle wins
  assign timeout_hit = (state_reg == ST_ACCESS) && !ack && (to_cnt_reg == TO_LAST);

  // Watchdog: cleared on entry to ACCESS, counts cycles spent waiting there
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt_reg <= '0;
    end else if (state_reg == ST_ACCESS) begin
      to_cnt_reg <= to_cnt_reg + 4'd1;
    end else if (start) begin
      to_cnt_reg <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Handshake FSM; request fields are loaded once and held for the whole access
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          // DONE accepts a new access directly, so back-to-back requests
          // see exactly one low cycle on req.
          if (start) begin
            state_reg <= ST_ACCESS;
            req_reg   <= 1'b1;
            we_reg    <= start_we;
            addr_reg  <= start_addr;
            wdata_reg <= start_wdata;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (ack || timeout_hit) begin
            state_reg <= ST_DONE;
            req_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/memory_stage.sv
// M stage of the 5-stage core: captures the X bundle, issues lw/sw through
// the dmem handshake engine, stalls upstream while an access is outstanding
// and resolves the registered writeback (we_w, rd_w, data_w) for W.
// Optional feature macro: MEM_TIMEOUT_EN (ack watchdog, code 7 on abort).
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int         ADDR_W      = ADDR_W_DEF,
  parameter logic [4:0] RSTATUS_REG = REG_RSTATUS,
  parameter logic [4:0] RA_REG      = REG_RA
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid_x,
  input  logic [31:0]           exec_out_x,
  input  logic [31:0]           rd_out1_x,
  input  logic                  exception_x,
  input  logic [31:0]           exception_out_x,
  input  logic [4:0]            rd_x,
  input  logic                  reg_we_x,
  input  logic                  isLw_x,
  input  logic                  isSw_x,
  input  logic                  isJal_x,
  input  logic                  isSetx_x,
  memory_stage_if.master        mem,
  output logic                  stall_m,
  output logic                  we_w,
  output logic [4:0]            rd_w,
  output logic [31:0]           data_w
);

  state_e            hs_state;
  logic              hs_complete;
  logic              hs_timeout;
  logic              hs_req;
  logic              hs_we;
  logic [ADDR_W-1:0] hs_addr;
  logic [31:0]       hs_wdata;

  logic is_mem;
  logic addr_ok;
  logic accept;
  logic start;

  cap_t cap_reg;
  wb_t  wb_reg;
  wb_t  wb_next;

  assign is_mem  = isLw_x | isSw_x;
  assign addr_ok = (exec_out_x[31:ADDR_W] == '0);

  // A new bundle is taken every cycle except while waiting on memory
  assign accept  = (hs_state != ST_ACCESS);
  assign stall_m = (hs_state == ST_ACCESS);

  // Only a clean, in-range lw/sw reaches memory; exceptions suppress it
  assign start = accept && valid_x && !exception_x && is_mem && addr_ok;

  memory_stage_dmem_handshake #(
    .ADDR_W      (ADDR_W)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (TIMEOUT_CYC)
`endif
  ) u_handshake (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .start_we    (isSw_x),
    .start_addr  (exec_out_x[ADDR_W-1:0]),
    .start_wdata (rd_out1_x),
    .ack         (mem.dmem_ack),
    .req         (hs_req),
    .we          (hs_we),
    .addr        (hs_addr),
    .wdata       (hs_wdata),
    .state       (hs_state),
    .complete    (hs_complete),
    .timeout_hit (hs_timeout)
  );

  assign mem.dmem_req   = hs_req;
  assign mem.dmem_we    = hs_we;
  assign mem.dmem_addr  = hs_addr;
  assign mem.dmem_wdata = hs_wdata;

  // Capture register: remembers load/rd of the bundle that starts an access
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cap_reg <= '0;
    end else if (accept) begin
      cap_reg.is_lw <= start & isLw_x;
      cap_reg.rd    <= rd_x;
    end
  end

  // Writeback select: memory completion while stalled, otherwise the
  // incoming bundle in priority order exception > range > setx > jal > rd
  always_comb begin
    wb_next = WB_NONE;
    if (hs_state == ST_ACCESS) begin
      if (hs_complete) begin
        if (cap_reg.is_lw) begin
          wb_next = make_wb(1'b1, cap_reg.rd, mem.dmem_rdata);
        end
      end else if (hs_timeout) begin
        wb_next = make_wb(1'b1, RSTATUS_REG, EXC_MEMTO);
      end
    end else if (valid_x) begin
      if (exception_x) begin
        wb_next = make_wb(1'b1, RSTATUS_REG, exception_out_x);
      end else if (is_mem) begin
        if (!addr_ok) begin
          wb_next = make_wb(1'b1, RSTATUS_REG, EXC_MEMRANGE);
        end
      end else if (isSetx_x) begin
        wb_next = make_wb(1'b1, RSTATUS_REG, exec_out_x);
      end else if (isJal_x) begin
        wb_next = make_wb(1'b1, RA_REG, exec_out_x);
      end else if (reg_we_x) begin
        wb_next = make_wb(1'b1, rd_x, exec_out_x);
      end
    end
  end

  // Registered writeback; each result is presented for exactly one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_reg <= WB_NONE;
    end else begin
      wb_reg <= wb_next;
    end
  end

  assign we_w   = wb_reg.we;
  assign rd_w   = wb_reg.rd;
  assign data_w = wb_reg.data;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: a table of single-cycle bundles,
// hand-written memory sequences, and a writeback scoreboard monitor.
// Timeout sequence is built when MEM_TIMEOUT_EN is defined.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        valid_x, exception_x, reg_we_x;
  logic        isLw_x, isSw_x, isJal_x, isSetx_x;
  logic [31:0] exec_out_x, rd_out1_x, exception_out_x;
  logic [4:0]  rd_x;
  logic        stall_m, we_w;
  logic [4:0]  rd_w;
  logic [31:0] data_w;

  int checks = 0;
  int errors = 0;

  memory_stage_if #(.ADDR_W(12)) mem_bus ();

  memory_stage dut (
    .clock           (clock),
    .reset           (reset),
    .valid_x         (valid_x),
    .exec_out_x      (exec_out_x),
    .rd_out1_x       (rd_out1_x),
    .exception_x     (exception_x),
    .exception_out_x (exception_out_x),
    .rd_x            (rd_x),
    .reg_we_x        (reg_we_x),
    .isLw_x          (isLw_x),
    .isSw_x          (isSw_x),
    .isJal_x         (isJal_x),
    .isSetx_x        (isSetx_x),
    .mem             (mem_bus),
    .stall_m         (stall_m),
    .we_w            (we_w),
    .rd_w            (rd_w),
    .data_w          (data_w)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [31:0] exec;
    logic        exc;
    logic [31:0] code;
    logic [4:0]  rd;
    logic        reg_we, lw, sw, jal, setx;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];

  function automatic vec_t mkv(input logic valid, input logic [31:0] exec,
                               input logic exc, input logic [31:0] code,
                               input logic [4:0] rd, input logic reg_we,
                               input logic lw, input logic sw, input logic jal,
                               input logic setx, input logic exp_we,
                               input logic [4:0] exp_rd, input logic [31:0] exp_data);
    vec_t v;
    v.valid = valid; v.exec = exec; v.exc = exc; v.code = code; v.rd = rd;
    v.reg_we = reg_we; v.lw = lw; v.sw = sw; v.jal = jal; v.setx = setx;
    v.exp_we = exp_we; v.exp_rd = exp_rd; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bubble();
    valid_x = 1'b0; exec_out_x = '0; rd_out1_x = '0; exception_x = 1'b0;
    exception_out_x = '0; rd_x = '0; reg_we_x = 1'b0; isLw_x = 1'b0;
    isSw_x = 1'b0; isJal_x = 1'b0; isSetx_x = 1'b0;
  endtask

  // Drive one bundle and record the writeback it must eventually produce
  task automatic drive_push(input vec_t v);
    valid_x = v.valid; exec_out_x = v.exec; rd_out1_x = '0; exception_x = v.exc;
    exception_out_x = v.code; rd_x = v.rd; reg_we_x = v.reg_we; isLw_x = v.lw;
    isSw_x = v.sw; isJal_x = v.jal; isSetx_x = v.setx;
    if (v.exp_we) sb.push_back({v.exp_rd, v.exp_data});
  endtask

  task automatic drive_mem(input logic lw, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] wdata);
    valid_x = 1'b1; exec_out_x = addr; rd_out1_x = wdata; exception_x = 1'b0;
    exception_out_x = '0; rd_x = rd; reg_we_x = lw; isLw_x = lw; isSw_x = !lw;
    isJal_x = 1'b0; isSetx_x = 1'b0;
  endtask

  // Called in the first ACCESS cycle; plays the memory with the given
  // latency and returns in the DONE cycle after checking its writeback.
  task automatic mem_access(input int lat, input logic [11:0] exp_addr,
                            input logic exp_store, input logic [31:0] exp_wdata,
                            input logic [31:0] rdata, input logic exp_wb,
                            input logic [4:0] exp_rd);
    $display("access addr=0x%03h store=%0b latency=%0d", exp_addr, exp_store, lat);
    for (int c = 1; c <= lat; c++) begin
      check("access_req", mem_bus.dmem_req, 1'b1);
      check("access_stall", stall_m, 1'b1);
      check("access_we", mem_bus.dmem_we, exp_store);
      check("access_addr", mem_bus.dmem_addr, exp_addr);
      check("access_wb_idle", we_w, 1'b0);
      if (exp_store) check("access_wdata", mem_bus.dmem_wdata, exp_wdata);
      if (c == lat) begin
        mem_bus.dmem_ack   = 1'b1;
        mem_bus.dmem_rdata = rdata;
      end
      tick();
      mem_bus.dmem_ack   = 1'b0;
      mem_bus.dmem_rdata = $urandom;
    end
    check("done_req", mem_bus.dmem_req, 1'b0);
    check("done_stall", stall_m, 1'b0);
    check("done_we_w", we_w, exp_wb);
    if (exp_wb) begin
      check("done_rd_w", rd_w, exp_rd);
      check("done_data_w", data_w, rdata);
    end
  endtask

  // Scoreboard monitor: every writeback pulse must match the oldest expectation
  initial begin
    forever begin
      @(negedge clock);
      if (reset && we_w) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb: got rd=%0d data=0x%08h expected no writeback", rd_w, data_w);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("wb rd=%0d data=0x%08h", rd_w, data_w);
          check("sb_rd", rd_w, e.rd);
          check("sb_data", data_w, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bubble();
    mem_bus.dmem_ack   = 1'b0;
    mem_bus.dmem_rdata = '0;

    vecs[0]  = mkv(1, 32'h2A,       0, 0, 5'd5, 1, 0, 0, 0, 0, 1, 5'd5,  32'h2A);
    vecs[1]  = mkv(1, 32'h44,       0, 0, 5'd0, 0, 0, 0, 1, 0, 1, 5'd31, 32'h44);
    vecs[2]  = mkv(1, 32'h7,        0, 0, 5'd0, 0, 0, 0, 0, 1, 1, 5'd30, 32'h7);
    vecs[3]  = mkv(1, 32'h5,        1, 1, 5'd3, 1, 0, 0, 0, 0, 1, 5'd30, 32'h1);
    vecs[4]  = mkv(1, 32'h1000,     0, 0, 5'd7, 1, 1, 0, 0, 0, 1, 5'd30, 32'h6);
    vecs[5]  = mkv(1, 32'hFFFFF010, 0, 0, 5'd0, 0, 0, 1, 0, 0, 1, 5'd30, 32'h6);
    vecs[6]  = mkv(1, 32'h123,      0, 0, 5'd0, 1, 0, 0, 0, 0, 0, 5'd0,  32'h0);
    vecs[7]  = mkv(0, 32'h456,      0, 0, 5'd4, 1, 0, 0, 0, 0, 0, 5'd0,  32'h0);
    vecs[8]  = mkv(1, 32'h789,      0, 0, 5'd6, 0, 0, 0, 0, 0, 0, 5'd0,  32'h0);
    vecs[9]  = mkv(1, 32'h20,       1, 5, 5'd7, 1, 1, 0, 0, 0, 1, 5'd30, 32'h5);
    vecs[10] = mkv(1, 32'h88,       1, 2, 5'd0, 0, 0, 0, 1, 0, 1, 5'd30, 32'h2);
    vecs[11] = mkv(1, 32'hDEADBEEF, 0, 0, 5'd31, 1, 0, 0, 0, 0, 1, 5'd31, 32'hDEADBEEF);

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_req", mem_bus.dmem_req, 1'b0);
    check("rst_dmem_we", mem_bus.dmem_we, 1'b0);
    check("rst_stall", stall_m, 1'b0);
    check("rst_we_w", we_w, 1'b0);
    check("rst_rd_w", rd_w, 5'd0);
    check("rst_data_w", data_w, 32'd0);
    reset = 1'b1;
    tick();

    // Single-cycle bundles: writeback appears one cycle after capture
    for (int i = 0; i < 12; i++) begin
      drive_push(vecs[i]);
      tick();
      check($sformatf("vec%0d_we_w", i), we_w, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d_rd_w", i), rd_w, vecs[i].exp_rd);
        check($sformatf("vec%0d_data_w", i), data_w, vecs[i].exp_data);
      end
      check($sformatf("vec%0d_stall", i), stall_m, 1'b0);
      check($sformatf("vec%0d_req", i), mem_bus.dmem_req, 1'b0);
    end
    bubble();
    tick();

    // sw 0x010/0xDEAD, ack after 3 cycles; the following add is held and
    // only captured in DONE
    drive_mem(1'b0, 5'd0, 32'h010, 32'hDEAD);
    tick();
    drive_push(mkv(1, 32'h99, 0, 0, 5'd9, 1, 0, 0, 0, 0, 1, 5'd9, 32'h99));
    mem_access(3, 12'h010, 1'b1, 32'hDEAD, 32'h0, 1'b0, 5'd0);
    tick();
    check("held_add_we_w", we_w, 1'b1);
    check("held_add_rd_w", rd_w, 5'd9);
    check("held_add_data_w", data_w, 32'h99);
    bubble();
    tick();

    // lw rd=7 from 0x020 (ack on cycle 2) immediately followed by a sw
    drive_mem(1'b1, 5'd7, 32'h020, 32'h0);
    sb.push_back({5'd7, 32'h1234});
    tick();
    drive_mem(1'b0, 5'd0, 32'h030, 32'hCAFE);
    mem_access(2, 12'h020, 1'b0, 32'h0, 32'h1234, 1'b1, 5'd7);
    tick();
    bubble();
    mem_access(1, 12'h030, 1'b1, 32'hCAFE, 32'h0, 1'b0, 5'd0);
    tick();

    // Load into $r0 completes but writes nothing
    drive_mem(1'b1, 5'd0, 32'h004, 32'h0);
    tick();
    bubble();
    mem_access(1, 12'h004, 1'b0, 32'h0, 32'h77, 1'b0, 5'd0);
    tick();

    // Ack while idle is ignored
    mem_bus.dmem_ack   = 1'b1;
    mem_bus.dmem_rdata = 32'h55;
    tick();
    mem_bus.dmem_ack   = 1'b0;
    check("idle_ack_req", mem_bus.dmem_req, 1'b0);
    check("idle_ack_stall", stall_m, 1'b0);
    check("idle_ack_we_w", we_w, 1'b0);

    // Reset pulled mid-ACCESS; a stale ack afterwards is ignored
    drive_mem(1'b1, 5'd8, 32'h040, 32'h0);
    tick();
    bubble();
    check("pre_rst_req", mem_bus.dmem_req, 1'b1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_req", mem_bus.dmem_req, 1'b0);
    check("async_rst_stall", stall_m, 1'b0);
    check("async_rst_we_w", we_w, 1'b0);
    check("async_rst_data_w", data_w, 32'd0);
    tick();
    reset = 1'b1;
    mem_bus.dmem_ack   = 1'b1;
    mem_bus.dmem_rdata = 32'hBAD;
    tick();
    mem_bus.dmem_ack   = 1'b0;
    check("stale_ack_req", mem_bus.dmem_req, 1'b0);
    check("stale_ack_stall", stall_m, 1'b0);
    check("stale_ack_we_w", we_w, 1'b0);
    tick();
    check("stale_ack_we_w2", we_w, 1'b0);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 15 ACCESS cycles with code 7, late ack ignored
    drive_mem(1'b1, 5'd9, 32'h050, 32'h0);
    sb.push_back({5'd30, 32'd7});
    tick();
    bubble();
    $display("access addr=0x050 store=0 latency=timeout");
    for (int c = 1; c <= 15; c++) begin
      check("to_req", mem_bus.dmem_req, 1'b1);
      check("to_stall", stall_m, 1'b1);
      tick();
    end
    check("to_done_req", mem_bus.dmem_req, 1'b0);
    check("to_done_stall", stall_m, 1'b0);
    check("to_we_w", we_w, 1'b1);
    check("to_rd_w", rd_w, 5'd30);
    check("to_data_w", data_w, 32'd7);
    mem_bus.dmem_ack   = 1'b1;
    mem_bus.dmem_rdata = 32'h600D;
    tick();
    mem_bus.dmem_ack   = 1'b0;
    check("late_ack_req", mem_bus.dmem_req, 1'b0);
    check("late_ack_we_w", we_w, 1'b0);
    check("late_ack_stall", stall_m, 1'b0);
`else
    // Without the watchdog a slow memory is simply waited for
    drive_mem(1'b1, 5'd9, 32'h050, 32'h0);
    sb.push_back({5'd9, 32'h600D});
    tick();
    bubble();
    mem_access(20, 12'h050, 1'b0, 32'h0, 32'h600D, 1'b1, 5'd9);
`endif

    bubble();
    repeat (3) tick();
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
